// File: rtl/vga_pattern_sequencer_if.sv
// Bus bundle between the UART / sync-pulse side and vga_pattern_sequencer.
// The slave modport is the sequencer's view; the master modport is the driver's view.
interface vga_pattern_sequencer_if #(
    parameter int PATTERN_WIDTH = 4
);
    logic                     i_RX_DV;
    logic [7:0]               i_RX_Byte;
    logic                     i_VSync;
    logic                     i_TX_Active;
    logic [PATTERN_WIDTH-1:0] o_Pattern;
    logic                     o_Auto_Mode;
    logic                     o_Frame_Strobe;
    logic                     o_Cmd_Err;
    logic                     o_TX_DV;
    logic [7:0]               o_TX_Byte;

    modport master (
        output i_RX_DV, i_RX_Byte, i_VSync, i_TX_Active,
        input  o_Pattern, o_Auto_Mode, o_Frame_Strobe, o_Cmd_Err, o_TX_DV, o_TX_Byte
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte, i_VSync, i_TX_Active,
        output o_Pattern, o_Auto_Mode, o_Frame_Strobe, o_Cmd_Err, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: UART-commanded pattern index for the VGA test-pattern generator.
// Commands queue a target index in r_Pending; the visible index o_Pattern only changes at the
// falling edge of VSync so a frame never shows two patterns. Auto mode advances every
// FRAMES_PER_PATTERN frames.
// Optional feature macro: PATTERN_SEQ_STATUS_EN (status echo byte back to the UART TX).
module vga_pattern_sequencer #(
    parameter int NUM_PATTERNS       = 8,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int PATTERN_WIDTH      = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    vga_pattern_sequencer_if.slave  bus
);

    localparam int PW  = PATTERN_WIDTH;
    localparam int FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [PW-1:0]  LAST_IDX   = PW'(NUM_PATTERNS - 1);
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(FRAMES_PER_PATTERN - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    // Increment an index with wrap NUM_PATTERNS-1 -> 0.
    function automatic logic [PW-1:0] f_inc_wrap(input logic [PW-1:0] v);
        return (v == LAST_IDX) ? '0 : v + 1'b1;
    endfunction

    // Decrement an index with wrap 0 -> NUM_PATTERNS-1.
    function automatic logic [PW-1:0] f_dec_wrap(input logic [PW-1:0] v);
        return (v == '0) ? LAST_IDX : v - 1'b1;
    endfunction

    state_t          r_State;
    state_t          w_State_Next;
    logic [PW-1:0]   r_Pattern;
    logic [PW-1:0]   w_Pattern_Next;
    logic [PW-1:0]   r_Pending;
    logic [PW-1:0]   w_Pending_Next;
    logic [FCW-1:0]  r_Frame_Cnt;
    logic [FCW-1:0]  w_Frame_Cnt_Next;
    logic            r_Cmd_Seen;
    logic            w_Cmd_Seen_Next;
    logic            r_VSync_d;
    logic            r_Frame_Strobe;
    logic            r_Cmd_Err;
    logic            w_Boundary;

    // Decoder results for the byte presented this cycle
    logic            w_Cmd_Touch;
    logic            w_Cmd_Err;
    logic            w_Cmd_Ok;
    logic            w_Go_Auto;
    logic            w_Go_Manual;
    logic [PW-1:0]   w_Pending_Cmd;

    assign w_Boundary = r_VSync_d & ~bus.i_VSync;

    // Decode one command byte into its effect on the queued index and the mode.
    always_comb begin
        w_Cmd_Touch   = 1'b0;
        w_Cmd_Err     = 1'b0;
        w_Cmd_Ok      = 1'b0;
        w_Go_Auto     = 1'b0;
        w_Go_Manual   = 1'b0;
        w_Pending_Cmd = r_Pending;
        if (bus.i_RX_DV) begin
            if (bus.i_RX_Byte[7:4] == 4'h3) begin
                if (32'(bus.i_RX_Byte[3:0]) < NUM_PATTERNS) begin
                    w_Pending_Cmd = PW'(bus.i_RX_Byte[3:0]);
                    w_Cmd_Touch   = 1'b1;
                    w_Go_Manual   = 1'b1;
                    w_Cmd_Ok      = 1'b1;
                end else begin
                    w_Cmd_Err = 1'b1;
                end
            end else begin
                case (bus.i_RX_Byte)
                    8'h6E: begin
                        w_Pending_Cmd = f_inc_wrap(r_Pending);
                        w_Cmd_Touch   = 1'b1;
                        w_Cmd_Ok      = 1'b1;
                    end
                    8'h70: begin
                        w_Pending_Cmd = f_dec_wrap(r_Pending);
                        w_Cmd_Touch   = 1'b1;
                        w_Cmd_Ok      = 1'b1;
                    end
                    8'h61: begin
                        w_Go_Auto = 1'b1;
                        w_Cmd_Ok  = 1'b1;
                    end
                    8'h6D: begin
                        w_Go_Manual = 1'b1;
                        w_Cmd_Ok    = 1'b1;
                    end
                    default: w_Cmd_Err = 1'b1;
                endcase
            end
        end
    end

    // Next-state and commit logic: the boundary commits state from before this cycle's command,
    // the command itself lands in r_Pending and is committed at the following boundary.
    always_comb begin
        w_State_Next     = r_State;
        w_Pattern_Next   = r_Pattern;
        w_Pending_Next   = w_Pending_Cmd;
        w_Frame_Cnt_Next = r_Frame_Cnt;
        w_Cmd_Seen_Next  = r_Cmd_Seen | w_Cmd_Touch;

        if (w_Boundary) begin
            w_Cmd_Seen_Next = w_Cmd_Touch;
            case (r_State)
                ST_MANUAL: begin
                    w_Pattern_Next = r_Pending;
                end
                ST_AUTO: begin
                    if (r_Cmd_Seen) begin
                        w_Pattern_Next   = r_Pending;
                        w_Frame_Cnt_Next = '0;
                    end else if (r_Frame_Cnt == LAST_FRAME) begin
                        w_Pattern_Next   = f_inc_wrap(r_Pattern);
                        w_Frame_Cnt_Next = '0;
                        // A command arriving in the same cycle keeps its own target
                        if (!w_Cmd_Touch) begin
                            w_Pending_Next = f_inc_wrap(r_Pattern);
                        end
                    end else begin
                        w_Frame_Cnt_Next = r_Frame_Cnt + 1'b1;
                    end
                end
                default: w_Pattern_Next = r_Pattern;
            endcase
        end

        // Entering auto restarts the frame count; select/'m' drop back to manual
        if (w_Go_Auto) begin
            w_State_Next     = ST_AUTO;
            w_Frame_Cnt_Next = '0;
        end else if (w_Go_Manual) begin
            w_State_Next = ST_MANUAL;
        end
    end

    // State, index and frame-count registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State        <= ST_MANUAL;
            r_Pattern      <= '0;
            r_Pending      <= '0;
            r_Frame_Cnt    <= '0;
            r_Cmd_Seen     <= 1'b0;
            r_VSync_d      <= 1'b0;
            r_Frame_Strobe <= 1'b0;
            r_Cmd_Err      <= 1'b0;
        end else begin
            r_State        <= w_State_Next;
            r_Pattern      <= w_Pattern_Next;
            r_Pending      <= w_Pending_Next;
            r_Frame_Cnt    <= w_Frame_Cnt_Next;
            r_Cmd_Seen     <= w_Cmd_Seen_Next;
            r_VSync_d      <= bus.i_VSync;
            r_Frame_Strobe <= w_Boundary;
            r_Cmd_Err      <= w_Cmd_Err;
        end
    end

    assign bus.o_Pattern      = r_Pattern;
    assign bus.o_Auto_Mode    = (r_State == ST_AUTO);
    assign bus.o_Frame_Strobe = r_Frame_Strobe;
    assign bus.o_Cmd_Err      = r_Cmd_Err;

`ifdef PATTERN_SEQ_STATUS_EN
    logic       r_Slot_Full;
    logic [7:0] r_Slot_Byte;
    logic       r_TX_DV;
    logic [7:0] r_TX_Byte;
    logic       w_Decoded;

    assign w_Decoded = w_Cmd_Ok | w_Cmd_Err;

    // One-deep echo slot: newest decoded byte overwrites an unsent one; drains when TX is idle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Slot_Full <= 1'b0;
            r_Slot_Byte <= 8'h00;
            r_TX_DV     <= 1'b0;
            r_TX_Byte   <= 8'h00;
        end else begin
            r_TX_DV <= 1'b0;
            if (r_Slot_Full && !bus.i_TX_Active) begin
                r_TX_DV     <= 1'b1;
                r_TX_Byte   <= r_Slot_Byte;
                r_Slot_Full <= 1'b0;
            end
            if (w_Decoded) begin
                r_Slot_Full <= 1'b1;
                r_Slot_Byte <= w_Cmd_Err ? 8'h3F : (8'h30 + 8'(w_Pending_Cmd));
            end
        end
    end

    assign bus.o_TX_DV   = r_TX_DV;
    assign bus.o_TX_Byte = r_TX_Byte;
`else
    logic w_unused_tx_active;
    assign w_unused_tx_active = bus.i_TX_Active;
    assign bus.o_TX_DV        = 1'b0;
    assign bus.o_TX_Byte      = 8'h00;
`endif

endmodule
